uart_cmd_rx: RTL and testbench

Receive-side companion of the statistics UART monitor. It deserializes bytes from the monitor's `uart_rx` line and parses framed commands that use the same header and checksum scheme as the outgoing statistics packets. It then drives the monitor's `enable` and `tx_interval` control inputs. It sits between the board UART RX pin and the monitor's control port.

---
 rtl/t2mi_uart_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 92 +++++++++
 rtl/uart_cmd_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/t2mi_uart_pkg.sv
// Shared constants for the statistics UART monitor and its command receiver.
// Header bytes and checksum scheme are common to both directions.
package t2mi_uart_pkg;

  localparam logic [7:0] HDR_SYNC0 = 8'hAA;
  localparam logic [7:0] HDR_SYNC1 = 8'h55;

  localparam logic [7:0] PKT_TYPE_STATS = 8'h01;

  localparam logic [7:0] CMD_SET_ENABLE   = 8'h10;
  localparam logic [7:0] CMD_SET_INTERVAL = 8'h11;
  localparam logic [7:0] CMD_CLR_COUNTERS = 8'h12;

  localparam logic [7:0] MAX_PAYLOAD = 8'd4;

  typedef enum logic [2:0] {
    StHuntAa,
    StHunt55,
    StType,
    StLen,
    StPayload,
    StCheck
  } parser_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, registered
// byte-valid and framing-error pulses issued the cycle after the stop sample.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e     state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q, frame_err_q;
  logic          fall, tick, stop_ok, stop_bad;

  assign fall = rx_prev_q & ~rx_sync_q;
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RxIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RxIdle:  if (fall) state_d = RxStart;
      // A start bit that reads high at mid-bit was a glitch: drop it silently.
      RxStart: if (tick) state_d = rx_sync_q ? RxIdle : RxData;
      RxData:  if (tick && bit_q == 3'd7) state_d = RxStop;
      RxStop:  if (tick) state_d = RxIdle;
      default: state_d = RxIdle;
    endcase
  end

  always_comb begin
    stop_ok  = (state_q == RxStop) && tick && rx_sync_q;
    stop_bad = (state_q == RxStop) && tick && !rx_sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= HALF_LOAD;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (state_q == RxIdle) cnt_q <= HALF_LOAD;
      else if (tick)         cnt_q <= BIT_LOAD;
      else                   cnt_q <= cnt_q - 1'b1;

      if (state_q == RxStart) bit_q <= 3'd0;
      else if (state_q == RxData && tick) begin
        bit_q   <= bit_q + 3'd1;
        shift_q <= {rx_sync_q, shift_q[7:1]};
      end

      byte_valid_q <= stop_ok;
      frame_err_q  <= stop_bad;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Command receiver for the statistics UART monitor: parses AA 55 TYPE LEN
// payload CHK frames and drives the monitor's enable and interval inputs.
module uart_cmd_rx
  import t2mi_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ         = 100_000_000,
  parameter int unsigned BAUD_RATE        = 115200,
  parameter int unsigned DEFAULT_INTERVAL = 1000,
  parameter int unsigned TIMEOUT_BITS     = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        mon_enable,
  output logic [15:0] tx_interval,
  output logic        cmd_valid,
  output logic [7:0]  cmd_type,
  output logic [15:0] frame_count,
  output logic [15:0] error_count,
  output logic        rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW           = $clog2(TIMEOUT_CLKS + 1);

  logic          byte_valid, frame_err;
  logic [7:0]    byte_data;

  parser_state_e state_q, state_d;
  logic [7:0]    type_q, len_q, sum_q;
  logic [2:0]    idx_q;
  logic [7:0]    buf_q [MAX_PAYLOAD];
  logic [TW-1:0] gap_q;

  logic          timeout, len_err, chk_fire, cmd_ok, accept, reject, err_inc;
  logic [7:0]    sum_chk;
  logic [15:0]   intv_val;

  logic          mon_enable_q, cmd_valid_q;
  logic [15:0]   tx_interval_q, frame_count_q, error_count_q;
  logic [7:0]    cmd_type_q;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign timeout = (state_q != StHuntAa) && !byte_valid && (gap_q == TW'(TIMEOUT_CLKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StHuntAa;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_err || timeout) begin
      state_d = StHuntAa;
    end else if (byte_valid) begin
      unique case (state_q)
        StHuntAa: if (byte_data == HDR_SYNC0) state_d = StHunt55;
        StHunt55: begin
          if (byte_data == HDR_SYNC1)      state_d = StType;
          else if (byte_data != HDR_SYNC0) state_d = StHuntAa;
        end
        StType:   state_d = StLen;
        StLen: begin
          if (byte_data > MAX_PAYLOAD) state_d = StHuntAa;
          else if (byte_data == 8'd0)  state_d = StCheck;
          else                         state_d = StPayload;
        end
        StPayload: if (8'(idx_q) + 8'd1 == len_q) state_d = StCheck;
        StCheck:   state_d = StHuntAa;
        default:   state_d = StHuntAa;
      endcase
    end
  end

  always_comb begin
    rx_busy  = (state_q != StHuntAa);
    len_err  = byte_valid && (state_q == StLen) && (byte_data > MAX_PAYLOAD);
    chk_fire = byte_valid && (state_q == StCheck);
    sum_chk  = sum_q + byte_data;
    intv_val = {buf_q[0], buf_q[1]};
    cmd_ok   = 1'b0;
    case (type_q)
      CMD_SET_ENABLE:   cmd_ok = (len_q == 8'd1);
      CMD_SET_INTERVAL: cmd_ok = (len_q == 8'd2) && (intv_val != 16'd0);
      CMD_CLR_COUNTERS: cmd_ok = (len_q == 8'd0);
      default:          cmd_ok = 1'b0;
    endcase
    accept  = chk_fire && (sum_chk == 8'h00) && cmd_ok;
    reject  = chk_fire && !accept;
    err_inc = frame_err || timeout || len_err || reject;
  end

  // Frame capture: running checksum starts at TYPE, payload lands in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q <= 8'h00;
      len_q  <= 8'h00;
      sum_q  <= 8'h00;
      idx_q  <= 3'd0;
      for (int i = 0; i < int'(MAX_PAYLOAD); i++) buf_q[i] <= 8'h00;
    end else if (byte_valid) begin
      case (state_q)
        StType: begin
          type_q <= byte_data;
          sum_q  <= byte_data;
        end
        StLen: begin
          len_q <= byte_data;
          sum_q <= sum_q + byte_data;
          idx_q <= 3'd0;
        end
        StPayload: begin
          buf_q[idx_q[1:0]] <= byte_data;
          sum_q             <= sum_q + byte_data;
          idx_q             <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   gap_q <= '0;
    else if (state_q == StHuntAa || byte_valid) gap_q <= '0;
    else                                       gap_q <= gap_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_enable_q  <= 1'b0;
      tx_interval_q <= 16'(DEFAULT_INTERVAL);
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= 8'h00;
      frame_count_q <= 16'h0000;
      error_count_q <= 16'h0000;
    end else begin
      cmd_valid_q <= accept;
      if (accept) begin
        cmd_type_q <= type_q;
        if (type_q == CMD_SET_ENABLE)   mon_enable_q  <= buf_q[0][0];
        if (type_q == CMD_SET_INTERVAL) tx_interval_q <= intv_val;
      end
      // The clearing frame itself is not counted.
      if (accept && type_q == CMD_CLR_COUNTERS) begin
        frame_count_q <= 16'h0000;
        error_count_q <= 16'h0000;
      end else begin
        if (accept && frame_count_q != 16'hFFFF) frame_count_q <= frame_count_q + 16'd1;
        if (err_inc && error_count_q != 16'hFFFF) error_count_q <= error_count_q + 16'd1;
      end
    end
  end

  assign mon_enable  = mon_enable_q;
  assign tx_interval = tx_interval_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign frame_count = frame_count_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: table of frames with cumulative expected
// register state, plus hand-written framing-error, timeout and reset cases.
module tb_uart_cmd_rx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 125_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        mon_enable, cmd_valid, rx_busy;
  logic [15:0] tx_interval, frame_count, error_count;
  logic [7:0]  cmd_type;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  uart_cmd_rx #(
    .CLK_FREQ        (CLK_FREQ),
    .BAUD_RATE       (BAUD),
    .DEFAULT_INTERVAL(1000),
    .TIMEOUT_BITS    (200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .mon_enable (mon_enable),
    .tx_interval(tx_interval),
    .cmd_valid  (cmd_valid),
    .cmd_type   (cmd_type),
    .frame_count(frame_count),
    .error_count(error_count),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && cmd_valid) pulses++;

  typedef struct {
    logic [127:0] bytes;
    int           n;
    logic         en;
    logic [15:0]  intv;
    logic [15:0]  fc;
    logic [15:0]  ec;
    logic [7:0]   typ;
    int           pulses;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_bits(input int bits);
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_seq(input logic [127:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b[(n-1-i)*8 +: 8], 1'b1);
  endtask

  task automatic check_all(input string tag, input logic en, input int intv, input int fc,
                           input int ec, input int typ, input int np, input logic busy);
    check({tag, " mon_enable"}, int'(mon_enable), int'(en));
    check({tag, " tx_interval"}, int'(tx_interval), intv);
    check({tag, " frame_count"}, int'(frame_count), fc);
    check({tag, " error_count"}, int'(error_count), ec);
    check({tag, " cmd_type"}, int'(cmd_type), typ);
    check({tag, " cmd_valid_pulses"}, pulses, np);
    check({tag, " rx_busy"}, int'(rx_busy), int'(busy));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            bytes                                      n   en    intv   fc  ec  typ    p
    vecs[0]  = '{128'hAA5511_0201F4F8,                       7, 1'b0, 16'd500,   1, 0, 8'h11, 1};
    vecs[1]  = '{128'hAA5510_0101EE,                         6, 1'b1, 16'd500,   2, 0, 8'h10, 2};
    vecs[2]  = '{128'hAA5510_0101EF,                         6, 1'b1, 16'd500,   2, 1, 8'h10, 2};
    vecs[3]  = '{128'hAA5520_00E0,                           5, 1'b1, 16'd500,   2, 2, 8'h10, 2};
    vecs[4]  = '{128'hAA5510_020001ED,                       7, 1'b1, 16'd500,   2, 3, 8'h10, 2};
    vecs[5]  = '{128'hAA5511_020000ED,                       7, 1'b1, 16'd500,   2, 4, 8'h10, 2};
    vecs[6]  = '{128'hAA5510_05,                             4, 1'b1, 16'd500,   2, 5, 8'h10, 2};
    vecs[7]  = '{128'hAA5510_01FEF1,                         6, 1'b0, 16'd500,   3, 5, 8'h10, 3};
    vecs[8]  = '{128'hAA5511_02FFFFEF,                       7, 1'b0, 16'd65535, 4, 5, 8'h11, 4};
    vecs[9]  = '{128'h00AA13_AA5511_020001EC,                10, 1'b0, 16'd1,     5, 5, 8'h11, 5};
    vecs[10] = '{128'hAA5510_0101EE_AA5511_0203E802,         13, 1'b1, 16'd1000,  7, 5, 8'h11, 7};
    vecs[11] = '{128'hAAAA55_1200EE,                         6, 1'b1, 16'd1000,  0, 0, 8'h12, 8};

    repeat (4) @(negedge clk);
    check_all("reset_held", 1'b0, 1000, 0, 0, 0, 0, 1'b0);
    check("reset_held cmd_valid", int'(cmd_valid), 0);
    rst = 1'b0;
    wait_bits(2);
    check_all("reset_rel", 1'b0, 1000, 0, 0, 0, 0, 1'b0);

    for (int v = 0; v < 12; v++) begin
      send_seq(vecs[v].bytes, vecs[v].n);
      wait_bits(3);
      check_all($sformatf("vec%0d", v), vecs[v].en, int'(vecs[v].intv), int'(vecs[v].fc),
                int'(vecs[v].ec), int'(vecs[v].typ), vecs[v].pulses, 1'b0);
    end

    // Framing error mid SET_INTERVAL: one error, frame aborted, trailing bytes ignored.
    send_seq(128'hAA551102, 4);
    check("ferr busy_mid", int'(rx_busy), 1);
    send_byte(8'h01, 1'b0);
    send_seq(128'hF4F8, 2);
    wait_bits(3);
    check_all("ferr", 1'b1, 1000, 0, 1, 8'h12, 8, 1'b0);

    // Inter-byte timeout after LEN, then a valid frame.
    send_seq(128'hAA551102, 4);
    wait_bits(190);
    check("tmo busy_before", int'(rx_busy), 1);
    check("tmo err_before", int'(error_count), 1);
    wait_bits(11);
    check("tmo busy_after", int'(rx_busy), 0);
    check("tmo err_after", int'(error_count), 2);
    send_seq(128'hAA5511_0201F4F8, 7);
    wait_bits(3);
    check_all("tmo_next", 1'b1, 500, 1, 2, 8'h11, 9, 1'b0);

    // Reset mid-payload and mid-byte.
    send_seq(128'hAA5510_0101EE, 6);
    wait_bits(3);
    check_all("pre_rst", 1'b1, 500, 2, 2, 8'h10, 10, 1'b0);
    send_seq(128'hAA551102_07, 5);
    uart_rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all("mid_rst", 1'b0, 1000, 0, 0, 0, 10, 1'b0);
    check("mid_rst cmd_valid", int'(cmd_valid), 0);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rst = 1'b0;
    wait_bits(2);
    check_all("post_rst", 1'b0, 1000, 0, 0, 0, 10, 1'b0);
    send_seq(128'hAA5511_0207D016, 7);
    wait_bits(3);
    check_all("post_rst_frame", 1'b0, 2000, 1, 0, 8'h11, 11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
